// File: rtl/axis_lockstep_checker.sv
// N-way AXI-Stream lockstep checker: per-channel FIFOs, group compare against channel 0, debug capture.
// Optional skew watchdog (err_timeout) is built only when LOCKSTEP_CHECKER_TIMEOUT_EN is defined.
module axis_lockstep_checker #(
  parameter int unsigned N                = 2,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned COMPARE_WIDTH    = 16,
  parameter int unsigned DEPTH            = 16,
  parameter int unsigned CNT_WIDTH        = 32,
  parameter int unsigned STOP_ON_MISMATCH = 0,
  parameter int unsigned TIMEOUT          = 1024
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [N*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [N-1:0]              s_axis_tvalid,
  output logic [N-1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic                      clr,
  output logic                      err_mismatch,
  output logic                      halted,
  output logic [CNT_WIDTH-1:0]      cmp_count,
  output logic [CNT_WIDTH-1:0]      mismatch_count,
  output logic [CNT_WIDTH-1:0]      first_idx,
  output logic [$clog2(N)-1:0]      first_chan,
  output logic [COMPARE_WIDTH-1:0]  first_exp,
  output logic [COMPARE_WIDTH-1:0]  first_got,
  output logic                      err_timeout
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CHW = $clog2(N);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem    [N][DEPTH];
  logic [AW-1:0]         wr_ptr [N];
  logic [AW-1:0]         rd_ptr [N];
  logic [AW:0]           count  [N];
  logic [DATA_WIDTH-1:0] head   [N];
  logic [N-1:0]          push;
  logic [N-1:0]          not_empty;
  logic                  running;
  logic                  fire;
  logic                  mismatch;
  logic [CHW-1:0]        mis_chan;
  logic [COMPARE_WIDTH-1:0] mis_got;
  logic [CNT_WIDTH-1:0]  cmp_base;
  logic [CNT_WIDTH-1:0]  mm_base;
  logic                  err_base;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // running keeps tready low until the first clock after reset release
  always_comb begin
    s_axis_tready = '0;
    push          = '0;
    not_empty     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      not_empty[i]     = (count[i] != '0);
      s_axis_tready[i] = running && (count[i] < FULL_CNT) && !halted;
      push[i]          = s_axis_tvalid[i] && s_axis_tready[i];
      head[i]          = mem[i][rd_ptr[i]];
    end
    fire = (&not_empty) && (!m_axis_tvalid || m_axis_tready) && !halted;
  end

  always_comb begin
    mismatch = 1'b0;
    mis_chan = '0;
    mis_got  = '0;
    for (int unsigned i = 1; i < N; i++) begin
      if ((head[i][COMPARE_WIDTH-1:0] != head[0][COMPARE_WIDTH-1:0]) && !mismatch) begin
        mismatch = 1'b1;
        mis_chan = CHW'(i);
        mis_got  = head[i][COMPARE_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      running <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      running <= 1'b1;
      for (int unsigned i = 0; i < N; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (fire)    rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !fire)      count[i] <= count[i] + 1'b1;
        else if (!push[i] && fire) count[i] <= count[i] - 1'b1;
      end
    end
  end

  // clr zeroes the base first so a same-cycle fire is recorded as the only event
  always_comb begin
    cmp_base = clr ? '0 : cmp_count;
    mm_base  = clr ? '0 : mismatch_count;
    err_base = clr ? 1'b0 : err_mismatch;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_axis_tvalid  <= 1'b0;
      m_axis_tdata   <= '0;
      cmp_count      <= '0;
      mismatch_count <= '0;
      err_mismatch   <= 1'b0;
      halted         <= 1'b0;
      first_idx      <= '0;
      first_chan     <= '0;
      first_exp      <= '0;
      first_got      <= '0;
    end else begin
      if (fire) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= head[0];
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      cmp_count      <= cmp_base;
      mismatch_count <= mm_base;
      err_mismatch   <= err_base;
      if (clr) begin
        halted     <= 1'b0;
        first_idx  <= '0;
        first_chan <= '0;
        first_exp  <= '0;
        first_got  <= '0;
      end
      if (fire) begin
        cmp_count <= sat_inc(cmp_base);
        if (mismatch) begin
          mismatch_count <= sat_inc(mm_base);
          err_mismatch   <= 1'b1;
          if (STOP_ON_MISMATCH != 0) halted <= 1'b1;
          if (!err_base) begin
            first_idx  <= cmp_base;
            first_chan <= mis_chan;
            first_exp  <= head[0][COMPARE_WIDTH-1:0];
            first_got  <= mis_got;
          end
        end
      end
    end
  end

`ifdef LOCKSTEP_CHECKER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] skew_cnt;
  logic          skew;

  always_comb begin
    skew = (|not_empty) && !(&not_empty);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      skew_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (clr || !skew)                  skew_cnt <= '0;
      else if (skew_cnt != TW'(TIMEOUT)) skew_cnt <= skew_cnt + 1'b1;
      if (clr)                                            err_timeout <= 1'b0;
      else if (skew && (skew_cnt >= TW'(TIMEOUT - 1)))   err_timeout <= 1'b1;
    end
  end
`else
  always_comb begin
    err_timeout = 1'b0;
  end
`endif

endmodule

// File: tb/tb_axis_lockstep_checker.sv
// Directed bench: a 3-channel compare/capture instance and a 2-channel stop-on-mismatch instance.
module tb_axis_lockstep_checker;

  logic ap_clk;
  logic ap_rst_n;

  logic [95:0] a_tdata;
  logic [2:0]  a_tvalid, a_tready;
  logic [31:0] a_mdata;
  logic        a_mvalid, a_mready, a_clr, a_err, a_halted, a_tmo;
  logic [3:0]  a_cmp, a_mm, a_fidx;
  logic [1:0]  a_fchan;
  logic [15:0] a_fexp, a_fgot;

  logic [63:0] b_tdata;
  logic [1:0]  b_tvalid, b_tready;
  logic [31:0] b_mdata;
  logic        b_mvalid, b_mready, b_clr, b_err, b_halted, b_tmo;
  logic [7:0]  b_cmp, b_mm, b_fidx;
  logic [0:0]  b_fchan;
  logic [15:0] b_fexp, b_fgot;

  int checks = 0;
  int errors = 0;

  logic [31:0] pa [3][24];
  logic [31:0] ea [24];
  int unsigned lim_a [3];
  int unsigned ia [3];
  int unsigned oa;
  logic [31:0] pb [2][24];
  logic [31:0] eb [24];
  int unsigned lim_b [2];
  int unsigned ib [2];
  int unsigned ob;

  axis_lockstep_checker #(
    .N(3), .DATA_WIDTH(32), .COMPARE_WIDTH(16), .DEPTH(4),
    .CNT_WIDTH(4), .STOP_ON_MISMATCH(0), .TIMEOUT(8)
  ) dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready),
    .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready),
    .clr(a_clr), .err_mismatch(a_err), .halted(a_halted),
    .cmp_count(a_cmp), .mismatch_count(a_mm), .first_idx(a_fidx),
    .first_chan(a_fchan), .first_exp(a_fexp), .first_got(a_fgot),
    .err_timeout(a_tmo)
  );

  axis_lockstep_checker #(
    .N(2), .DATA_WIDTH(32), .COMPARE_WIDTH(16), .DEPTH(4),
    .CNT_WIDTH(8), .STOP_ON_MISMATCH(1), .TIMEOUT(8)
  ) dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
    .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready),
    .clr(b_clr), .err_mismatch(b_err), .halted(b_halted),
    .cmp_count(b_cmp), .mismatch_count(b_mm), .first_idx(b_fidx),
    .first_chan(b_fchan), .first_exp(b_fexp), .first_got(b_fgot),
    .err_timeout(b_tmo)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rewind();
    for (int c = 0; c < 3; c++) ia[c] = 0;
    for (int c = 0; c < 2; c++) ib[c] = 0;
    oa = 0;
    ob = 0;
  endtask

  // one clock: offer words per channel, check accepted output words, advance on handshake
  task automatic step();
    logic [2:0] acc_a;
    logic [1:0] acc_b;
    for (int c = 0; c < 3; c++) begin
      a_tvalid[c] = (ia[c] < lim_a[c]);
      a_tdata[c*32 +: 32] = (ia[c] < 24) ? pa[c][ia[c]] : 32'h0;
    end
    for (int c = 0; c < 2; c++) begin
      b_tvalid[c] = (ib[c] < lim_b[c]);
      b_tdata[c*32 +: 32] = (ib[c] < 24) ? pb[c][ib[c]] : 32'h0;
    end
    acc_a = a_tvalid & a_tready;
    acc_b = b_tvalid & b_tready;
    if (a_mvalid && a_mready) begin
      if (oa < 24) chk("a_out_word", 64'(a_mdata), 64'(ea[oa]));
      oa++;
    end
    if (b_mvalid && b_mready) begin
      if (ob < 24) chk("b_out_word", 64'(b_mdata), 64'(eb[ob]));
      ob++;
    end
    @(posedge ap_clk);
    #1;
    for (int c = 0; c < 3; c++) if (acc_a[c]) ia[c]++;
    for (int c = 0; c < 2; c++) if (acc_b[c]) ib[c]++;
  endtask

  initial begin
    ap_rst_n = 1'b0;
    a_tdata = '0; a_tvalid = '0; a_mready = 1'b1; a_clr = 1'b0;
    b_tdata = '0; b_tvalid = '0; b_mready = 1'b1; b_clr = 1'b0;
    for (int c = 0; c < 3; c++) lim_a[c] = 0;
    for (int c = 0; c < 2; c++) lim_b[c] = 0;
    rewind();
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_a_tready", 64'(a_tready), 64'h0);
    chk("rst_b_tready", 64'(b_tready), 64'h0);
    chk("rst_a_mvalid", 64'(a_mvalid), 64'h0);
    chk("rst_a_cmp", 64'(a_cmp), 64'h0);
    chk("rst_a_err", 64'(a_err), 64'h0);
    chk("rst_b_halted", 64'(b_halted), 64'h0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("run_a_tready", 64'(a_tready), 64'h7);
    chk("run_b_tready", 64'(b_tready), 64'h3);

    // identical stream: each word appears one cycle after its fire
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) pa[c][k] = 32'((k + 1) * 16);
      ea[k] = 32'((k + 1) * 16);
    end
    rewind();
    for (int c = 0; c < 3; c++) lim_a[c] = 3;
    step(); chk("t1_mvalid_c1", 64'(a_mvalid), 64'h0);
    step(); chk("t1_mdata_c2", 64'(a_mdata), 64'h10); chk("t1_mvalid_c2", 64'(a_mvalid), 64'h1);
    step(); chk("t1_mdata_c3", 64'(a_mdata), 64'h20);
    step(); chk("t1_mdata_c4", 64'(a_mdata), 64'h30); chk("t1_mvalid_c4", 64'(a_mvalid), 64'h1);
    step(); chk("t1_mvalid_c5", 64'(a_mvalid), 64'h0);
    chk("t1_cmp", 64'(a_cmp), 64'h3);
    chk("t1_err", 64'(a_err), 64'h0);
    chk("t1_nout", 64'(oa), 64'h3);

    // upper-bit difference ignored, low-bit difference on word 7 captured
    a_clr = 1'b1; step(); a_clr = 1'b0;
    chk("t2_clr_cmp", 64'(a_cmp), 64'h0);
    for (int k = 0; k < 8; k++) begin
      logic [31:0] d;
      d = (k == 5 || k == 7) ? 32'h1234 : 32'(32'h1000 + k);
      for (int c = 0; c < 3; c++) pa[c][k] = d;
      ea[k] = d;
    end
    pa[2][5] = 32'h0001_1234;
    pa[2][7] = 32'h0000_1235;
    rewind();
    for (int c = 0; c < 3; c++) lim_a[c] = 8;
    repeat (7) step();
    chk("t2_cmp_mid", 64'(a_cmp), 64'h6);
    chk("t2_err_mid", 64'(a_err), 64'h0);
    repeat (3) step();
    chk("t2_cmp", 64'(a_cmp), 64'h8);
    chk("t2_mm", 64'(a_mm), 64'h1);
    chk("t2_err", 64'(a_err), 64'h1);
    chk("t2_fidx", 64'(a_fidx), 64'h7);
    chk("t2_fchan", 64'(a_fchan), 64'h2);
    chk("t2_fexp", 64'(a_fexp), 64'h1234);
    chk("t2_fgot", 64'(a_fgot), 64'h1235);
    chk("t2_halted", 64'(a_halted), 64'h0);
    chk("t2_nout", 64'(oa), 64'h8);

    // clr coinciding with a mismatching fire; channels 1 and 2 both differ
    pa[0][0] = 32'h55; pa[1][0] = 32'h56; pa[2][0] = 32'h57; ea[0] = 32'h55;
    rewind();
    for (int c = 0; c < 3; c++) lim_a[c] = 1;
    step();
    a_clr = 1'b1; step(); a_clr = 1'b0;
    chk("t3_cmp", 64'(a_cmp), 64'h1);
    chk("t3_mm", 64'(a_mm), 64'h1);
    chk("t3_err", 64'(a_err), 64'h1);
    chk("t3_fidx", 64'(a_fidx), 64'h0);
    chk("t3_fchan", 64'(a_fchan), 64'h1);
    chk("t3_fexp", 64'(a_fexp), 64'h55);
    chk("t3_fgot", 64'(a_fgot), 64'h56);
    step();
    a_clr = 1'b1; step(); a_clr = 1'b0;
    chk("t4_cmp", 64'(a_cmp), 64'h0);
    chk("t4_mm", 64'(a_mm), 64'h0);
    chk("t4_err", 64'(a_err), 64'h0);
    chk("t4_fchan", 64'(a_fchan), 64'h0);
    chk("t4_fexp", 64'(a_fexp), 64'h0);
    chk("t4_fgot", 64'(a_fgot), 64'h0);

    // skew: channel 2 stalled until channels 0/1 fill their FIFOs
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 3; c++) pa[c][k] = 32'(32'hA00 + k);
      ea[k] = 32'(32'hA00 + k);
    end
    rewind();
    lim_a[0] = 6; lim_a[1] = 6; lim_a[2] = 0;
    repeat (6) step();
    chk("t5_tready", 64'(a_tready), 64'h4);
    chk("t5_mvalid", 64'(a_mvalid), 64'h0);
    chk("t5_acc0", 64'(ia[0]), 64'h4);
    lim_a[2] = 6;
    repeat (14) step();
    chk("t5_nout", 64'(oa), 64'h6);
    chk("t5_cmp", 64'(a_cmp), 64'h6);
    chk("t5_mm", 64'(a_mm), 64'h0);
    chk("t5_mvalid_end", 64'(a_mvalid), 64'h0);
`ifndef LOCKSTEP_CHECKER_TIMEOUT_EN
    chk("t5_tmo_off", 64'(a_tmo), 64'h0);
`endif

    // backpressure: output held, FIFOs fill, then drain in order
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 3; c++) pa[c][k] = 32'(32'hB00 + k);
      ea[k] = 32'(32'hB00 + k);
    end
    rewind();
    for (int c = 0; c < 3; c++) lim_a[c] = 8;
    a_mready = 1'b0;
    repeat (5) step();
    chk("t6_mdata_mid", 64'(a_mdata), 64'hB00);
    chk("t6_mvalid_mid", 64'(a_mvalid), 64'h1);
    repeat (5) step();
    chk("t6_mdata_hold", 64'(a_mdata), 64'hB00);
    chk("t6_tready_full", 64'(a_tready), 64'h0);
    chk("t6_cmp_hold", 64'(a_cmp), 64'h7);
    chk("t6_acc0", 64'(ia[0]), 64'h5);
    chk("t6_acc2", 64'(ia[2]), 64'h5);
    a_mready = 1'b1;
    repeat (12) step();
    chk("t6_nout", 64'(oa), 64'h8);
    chk("t6_cmp", 64'(a_cmp), 64'hE);
    chk("t6_mvalid_end", 64'(a_mvalid), 64'h0);

    // 20 mismatching groups into 4-bit counters: both saturate at 15
    a_clr = 1'b1; step(); a_clr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      pa[0][k] = 32'(32'hC00 + k);
      pa[1][k] = 32'(32'hC00 + k) ^ 32'h1;
      pa[2][k] = 32'(32'hC00 + k);
      ea[k]    = 32'(32'hC00 + k);
    end
    rewind();
    for (int c = 0; c < 3; c++) lim_a[c] = 20;
    repeat (26) step();
    chk("t7_cmp_sat", 64'(a_cmp), 64'hF);
    chk("t7_mm_sat", 64'(a_mm), 64'hF);
    chk("t7_fidx", 64'(a_fidx), 64'h0);
    chk("t7_fchan", 64'(a_fchan), 64'h1);
    chk("t7_fgot", 64'(a_fgot), 64'h0C01);
    chk("t7_nout", 64'(oa), 64'd20);
    for (int c = 0; c < 3; c++) lim_a[c] = 0;

    // stop-on-mismatch: group 3 differs, halt, drain, clr resumes from FIFO
    for (int k = 0; k < 6; k++) begin
      pb[0][k] = 32'(32'hD00 + k);
      pb[1][k] = (k == 3) ? 32'hE03 : 32'(32'hD00 + k);
      eb[k]    = 32'(32'hD00 + k);
    end
    rewind();
    lim_b[0] = 6; lim_b[1] = 6;
    repeat (5) step();
    chk("t8_halted", 64'(b_halted), 64'h1);
    chk("t8_tready", 64'(b_tready), 64'h0);
    chk("t8_mvalid", 64'(b_mvalid), 64'h1);
    chk("t8_mdata", 64'(b_mdata), 64'hD03);
    chk("t8_cmp", 64'(b_cmp), 64'h4);
    chk("t8_mm", 64'(b_mm), 64'h1);
    chk("t8_fidx", 64'(b_fidx), 64'h3);
    chk("t8_fchan", 64'(b_fchan), 64'h1);
    chk("t8_fexp", 64'(b_fexp), 64'hD03);
    chk("t8_fgot", 64'(b_fgot), 64'hE03);
    repeat (3) step();
    chk("t8_nout_halt", 64'(ob), 64'h4);
    chk("t8_mvalid_drain", 64'(b_mvalid), 64'h0);
    chk("t8_still_halted", 64'(b_halted), 64'h1);
    chk("t8_acc0", 64'(ib[0]), 64'h5);
    chk("t8_cmp_frozen", 64'(b_cmp), 64'h4);
    b_clr = 1'b1; step(); b_clr = 1'b0;
    chk("t9_halted", 64'(b_halted), 64'h0);
    chk("t9_cmp", 64'(b_cmp), 64'h0);
    chk("t9_mm", 64'(b_mm), 64'h0);
    chk("t9_err", 64'(b_err), 64'h0);
    chk("t9_fgot", 64'(b_fgot), 64'h0);
    chk("t9_tready", 64'(b_tready), 64'h3);
    repeat (6) step();
    chk("t9_nout", 64'(ob), 64'h6);
    chk("t9_cmp_resume", 64'(b_cmp), 64'h2);
    chk("t9_err_resume", 64'(b_err), 64'h0);
`ifndef LOCKSTEP_CHECKER_TIMEOUT_EN
    chk("t9_tmo_off", 64'(b_tmo), 64'h0);
`endif
    lim_b[0] = 0; lim_b[1] = 0;

`ifdef LOCKSTEP_CHECKER_TIMEOUT_EN
    // only channel 0 holds data: watchdog trips after 8 skewed cycles
    a_clr = 1'b1; step(); a_clr = 1'b0;
    pa[0][0] = 32'hF0;
    rewind();
    lim_a[0] = 1; lim_a[1] = 0; lim_a[2] = 0;
    repeat (4) step();
    chk("t10_tmo_early", 64'(a_tmo), 64'h0);
    repeat (8) step();
    chk("t10_tmo_set", 64'(a_tmo), 64'h1);
    chk("t10_no_halt", 64'(a_halted), 64'h0);
    a_clr = 1'b1; step(); a_clr = 1'b0;
    chk("t10_tmo_clr", 64'(a_tmo), 64'h0);
    lim_a[0] = 0;
`endif

    // asynchronous reset with data queued: FIFOs flushed
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) pa[c][k] = 32'(32'h700 + k);
      ea[k] = 32'(32'h700 + k);
    end
    rewind();
    for (int c = 0; c < 3; c++) lim_a[c] = 3;
    a_mready = 1'b0;
    repeat (5) step();
    chk("t11_mvalid_pre", 64'(a_mvalid), 64'h1);
    ap_rst_n = 1'b0;
    #1;
    chk("t11_mvalid_rst", 64'(a_mvalid), 64'h0);
    chk("t11_mdata_rst", 64'(a_mdata), 64'h0);
    chk("t11_tready_rst", 64'(a_tready), 64'h0);
    chk("t11_bcmp_rst", 64'(b_cmp), 64'h0);
    for (int c = 0; c < 3; c++) lim_a[c] = 0;
    a_mready = 1'b1;
    #2;
    ap_rst_n = 1'b1;
    repeat (3) step();
    chk("t11_mvalid_post", 64'(a_mvalid), 64'h0);
    chk("t11_cmp_post", 64'(a_cmp), 64'h0);
    chk("t11_tready_post", 64'(a_tready), 64'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_lockstep_checker.md
Name: axis_lockstep_checker

Overview:
- Synthesizable N-way AXI-Stream equivalence checker for redundant or lockstep compute instances, e.g. mvu_vvu_axi variants differing only in ACCU_WIDTH.
- Buffers each channel in its own FIFO and pops all heads together once every channel has data.
- Compares each channel against channel 0 and forwards channel 0 downstream.
- Keeps sticky error state, saturating counters and a first-mismatch capture for debug and on-board self-test.

Parameters:
- N, 2, number of compared channels (>=2).
- DATA_WIDTH, 32, per-channel stream width.
- COMPARE_WIDTH, 16, LSBs compared (1..DATA_WIDTH); upper bits ignored.
- DEPTH, 16, per-channel FIFO depth; power of two, >=2.
- CNT_WIDTH, 32, width of counters and index capture.
- STOP_ON_MISMATCH, 0, 1 = halt all traffic after first mismatch.
- TIMEOUT, 1024, skew watchdog limit in cycles (used only with the optional feature).

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  N*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  N  per-channel valid.
- s_axis_tready  out  N  per-channel ready.
- m_axis_tdata  out  DATA_WIDTH  channel 0 word after comparison.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- clr  in  1  synchronous clear of error state and counters.
- err_mismatch  out  1  sticky mismatch flag.
- halted  out  1  high while stopped due to STOP_ON_MISMATCH.
- cmp_count  out  CNT_WIDTH  compared word groups.
- mismatch_count  out  CNT_WIDTH  mismatching word groups.
- first_idx  out  CNT_WIDTH  cmp_count value of the first mismatching group.
- first_chan  out  $clog2(N)  lowest mismatching channel in that group.
- first_exp  out  COMPARE_WIDTH  channel 0 value at the first mismatch.
- first_got  out  COMPARE_WIDTH  first_chan value at the first mismatch.
- err_timeout  out  1  sticky skew timeout (feature only; otherwise tied 0).

Behaviour:
- Reset: all outputs 0, FIFOs empty, s_axis_tready 0 during reset.
- FIFOs:
  - Count-based, registered occupancy.
  - s_axis_tready[i] = (count_i < DEPTH) && !halted.
  - No push when full; no same-cycle full bypass.
  - Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Fire condition: all N FIFOs non-empty, AND (!m_axis_tvalid || m_axis_tready), AND !halted.
- On fire at cycle t, all heads pop together. At t+1:
  - m_axis_tdata = channel 0 head; m_axis_tvalid = 1.
  - cmp_count incremented.
  - On mismatch: mismatch_count incremented; err_mismatch set.
- Mismatch rule: any channel i>0 with head[COMPARE_WIDTH-1:0] != channel 0 head[COMPARE_WIDTH-1:0].
- First-mismatch capture: first_* are loaded only when err_mismatch was 0 before the event; first_idx takes the pre-increment cmp_count.
- m_axis_tvalid:
  - Held with stable data until m_axis_tready.
  - Cleared after consumption if no fire occurs in the same cycle.
  - Back-to-back fires give one word per cycle.
- Counters saturate at all-ones and never wrap.
- STOP_ON_MISMATCH=1:
  - halted set together with err_mismatch; all tready drop and firing stops.
  - The pending m_axis word (the mismatching group) still drains.
- STOP_ON_MISMATCH=0: halted stays 0.
- clr (highest priority except a same-cycle mismatch):
  - Zeroes the counters and all sticky flags, including halted.
  - Zeroes first_* as well.
  - FIFO contents are preserved.
- clr in the same cycle as a mismatching fire: the result reflects only the new event: cmp_count=1, mismatch_count=1, err_mismatch=1, first_idx=0.
- Reset mid-operation: FIFOs flushed, everything returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: LOCKSTEP_CHECKER_TIMEOUT_EN.
- Enabled:
  - A skew counter increments each cycle in which at least one FIFO is non-empty and at least one is empty.
  - It resets to 0 otherwise, and on clr.
  - Reaching TIMEOUT sets sticky err_timeout, which clr clears.
  - err_timeout does not halt traffic.
- Disabled: err_timeout tied 0 and no counter is instantiated.

Test Plan:
- N=2, DEPTH=4: feed 0x10,0x20,0x30 identically on both channels, m_axis_tready=1 → m_axis emits 0x10,0x20,0x30 back-to-back, each one cycle after its fire; cmp_count=3; err_mismatch=0.
- N=3, COMPARE_WIDTH=16: channel 2 word #5 = 0x0001_1234 vs expected 0x0000_1234 → no mismatch (upper bits ignored).
  - Then word #7: 0x1235 vs 0x1234 → err_mismatch=1, first_idx=7, first_chan=2, first_exp=0x1234, first_got=0x1235, mismatch_count=1.
- Skew: channel 1 stalled while channel 0 sends 20 words, DEPTH=16 → s_axis_tready[0]=0 after 16 words and m_axis_tvalid=0.
  - Releasing channel 1 → all 20 groups compare equal, in order.
- Backpressure: m_axis_tready held low for 10 cycles → m_axis_tdata stable, no pops, FIFOs fill to DEPTH, then drain correctly once released.
- STOP_ON_MISMATCH=1: mismatch at group 3 → halted=1 and all tready=0 the next cycle; the mismatching word still drains.
  - Pulse clr → counters 0, halted=0, traffic resumes from the preserved FIFO contents.
- With LOCKSTEP_CHECKER_TIMEOUT_EN, TIMEOUT=8: only channel 0 sends → err_timeout=1 after 8 cycles of skew; clr clears it.
